// File: rtl/cache_pkg.sv
// Shared widths, FSM state encoding and byte helpers for the direct-mapped data cache.
package cache_pkg;

    localparam int unsigned NUM_BLOCKS  = 8;
    localparam int unsigned BLOCK_BYTES = 4;
    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned IDX_W       = 3;
    localparam int unsigned OFF_W       = 2;
    localparam int unsigned TAG_W       = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned LINE_W      = BLOCK_BYTES * 8;
    localparam int unsigned BLK_ADDR_W  = TAG_W + IDX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WBACK = 2'd1,
        FETCH = 2'd2,
        ALLOC = 2'd3
    } state_t;

    function automatic logic [7:0] get_byte(input logic [LINE_W-1:0] line,
                                            input logic [OFF_W-1:0]  off);
        return line[off*8 +: 8];
    endfunction

    function automatic logic [LINE_W-1:0] merge_byte(input logic [LINE_W-1:0] line,
                                                     input logic [OFF_W-1:0]  off,
                                                     input logic [7:0]        data);
        logic [LINE_W-1:0] res;
        res = line;
        res[off*8 +: 8] = data;
        return res;
    endfunction

endpackage

// File: rtl/data_cache_if.sv
// CPU-side and memory-side signals of the data cache; slave = cache view, master = environment view.
interface data_cache_if;
    import cache_pkg::*;

    logic                  READ;
    logic                  WRITE;
    logic [ADDR_W-1:0]     ADDRESS;
    logic [7:0]            WRITEDATA;
    logic [7:0]            READDATA;
    logic                  BUSYWAIT;
    logic                  MEM_READ;
    logic                  MEM_WRITE;
    logic [BLK_ADDR_W-1:0] MEM_ADDRESS;
    logic [LINE_W-1:0]     MEM_WRITEDATA;
    logic [LINE_W-1:0]     MEM_READDATA;
    logic                  MEM_BUSYWAIT;

    modport slave (
        input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );

    modport master (
        output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );

endinterface

// File: rtl/dcache_ctrl.sv
// Miss-handling FSM: optional writeback of the victim line, block fetch, then line allocation.
module dcache_ctrl
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss,
    input  logic                  victim_dirty,
    input  logic [TAG_W-1:0]      victim_tag,
    input  logic [LINE_W-1:0]     victim_line,
    input  logic [BLK_ADDR_W-1:0] req_blk,
    input  logic                  mem_busywait,
    input  logic [LINE_W-1:0]     mem_readdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [BLK_ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0]     mem_writedata,
    output logic                  idle,
    output logic                  alloc_en,
    output logic [IDX_W-1:0]      alloc_idx,
    output logic [TAG_W-1:0]      alloc_tag,
    output logic [LINE_W-1:0]     alloc_data
);

    state_t                state_q, state_d;
    logic [BLK_ADDR_W-1:0] blk_q, blk_d;
    logic [LINE_W-1:0]     fill_q, fill_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [BLK_ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [LINE_W-1:0]     mem_writedata_q, mem_writedata_d;

    always_comb begin
        state_d         = state_q;
        blk_d           = blk_q;
        fill_d          = fill_q;
        mem_read_d      = mem_read_q;
        mem_write_d     = mem_write_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;
        unique case (state_q)
            IDLE: begin
                if (miss) begin
                    // The missing block address is latched so the fill targets it even if ADDRESS moves.
                    blk_d = req_blk;
                    if (victim_dirty) begin
                        state_d         = WBACK;
                        mem_write_d     = 1'b1;
                        mem_address_d   = {victim_tag, req_blk[IDX_W-1:0]};
                        mem_writedata_d = victim_line;
                    end else begin
                        state_d       = FETCH;
                        mem_read_d    = 1'b1;
                        mem_address_d = req_blk;
                    end
                end
            end
            WBACK: begin
                if (!mem_busywait) begin
                    state_d       = FETCH;
                    mem_write_d   = 1'b0;
                    mem_read_d    = 1'b1;
                    mem_address_d = blk_q;
                end
            end
            FETCH: begin
                if (!mem_busywait) begin
                    state_d    = ALLOC;
                    mem_read_d = 1'b0;
                    fill_d     = mem_readdata;
                end
            end
            ALLOC: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            blk_q           <= '0;
            fill_q          <= '0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
        end else begin
            state_q         <= state_d;
            blk_q           <= blk_d;
            fill_q          <= fill_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
        end
    end

    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_writedata_q;
    assign idle          = (state_q == IDLE);
    assign alloc_en      = (state_q == ALLOC);
    assign alloc_idx     = blk_q[IDX_W-1:0];
    assign alloc_tag     = blk_q[BLK_ADDR_W-1:IDX_W];
    assign alloc_data    = fill_q;

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate byte cache: line arrays, hit detection and byte access.
module data_cache
    import cache_pkg::*;
(
    input  logic         CLK,
    input  logic         RESET,
    data_cache_if.slave  bus
);

    logic [LINE_W-1:0]     data_q [NUM_BLOCKS];
    logic [LINE_W-1:0]     data_d [NUM_BLOCKS];
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [TAG_W-1:0]      tag_d  [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] valid_q, valid_d;
    logic [NUM_BLOCKS-1:0] dirty_q, dirty_d;
    logic [7:0]            readdata_q, readdata_d;

    logic [TAG_W-1:0] a_tag;
    logic [IDX_W-1:0] a_idx;
    logic [OFF_W-1:0] a_off;
    logic             req, hit, idle, acc_hit, rd_hit, wr_hit, miss;
    logic [7:0]       sel_byte;
    logic             alloc_en;
    logic [IDX_W-1:0] alloc_idx;
    logic [TAG_W-1:0] alloc_tag;
    logic [LINE_W-1:0] alloc_data;

    assign a_tag = bus.ADDRESS[ADDR_W-1:IDX_W+OFF_W];
    assign a_idx = bus.ADDRESS[IDX_W+OFF_W-1:OFF_W];
    assign a_off = bus.ADDRESS[OFF_W-1:0];

    assign req      = bus.READ | bus.WRITE;
    assign hit      = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
    assign acc_hit  = idle && hit;
    // READ wins when both strobes are high.
    assign rd_hit   = acc_hit && bus.READ;
    assign wr_hit   = acc_hit && bus.WRITE && !bus.READ;
    assign miss     = req && idle && !hit;
    assign sel_byte = get_byte(data_q[a_idx], a_off);

    assign bus.BUSYWAIT = req && !acc_hit;
    assign bus.READDATA = rd_hit ? sel_byte : readdata_q;

    dcache_ctrl u_ctrl (
        .clk          (CLK),
        .rst          (RESET),
        .miss         (miss),
        .victim_dirty (dirty_q[a_idx]),
        .victim_tag   (tag_q[a_idx]),
        .victim_line  (data_q[a_idx]),
        .req_blk      (bus.ADDRESS[ADDR_W-1:OFF_W]),
        .mem_busywait (bus.MEM_BUSYWAIT),
        .mem_readdata (bus.MEM_READDATA),
        .mem_read     (bus.MEM_READ),
        .mem_write    (bus.MEM_WRITE),
        .mem_address  (bus.MEM_ADDRESS),
        .mem_writedata(bus.MEM_WRITEDATA),
        .idle         (idle),
        .alloc_en     (alloc_en),
        .alloc_idx    (alloc_idx),
        .alloc_tag    (alloc_tag),
        .alloc_data   (alloc_data)
    );

    always_comb begin
        data_d     = data_q;
        tag_d      = tag_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        readdata_d = rd_hit ? sel_byte : readdata_q;
        if (wr_hit) begin
            data_d[a_idx]  = merge_byte(data_q[a_idx], a_off, bus.WRITEDATA);
            dirty_d[a_idx] = 1'b1;
        end
        if (alloc_en) begin
            data_d[alloc_idx]  = alloc_data;
            tag_d[alloc_idx]   = alloc_tag;
            valid_d[alloc_idx] = 1'b1;
            dirty_d[alloc_idx] = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q    <= '0;
            dirty_q    <= '0;
            readdata_q <= '0;
        end else begin
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            readdata_q <= readdata_d;
        end
    end

    // Line storage is deliberately not reset; valid bits alone guard it.
    always_ff @(posedge CLK) begin
        data_q <= data_d;
        tag_q  <= tag_d;
    end

endmodule
